// File: rtl/add_one_stream_bridge.sv
// Avalon-MM bridge that queues 64-bit operands for the add_one HLS component and buffers its results.
// Define ADD_ONE_BRIDGE_CHECK_EN to build the shadow FIFO that checks every result against operand+1.

module add_one_stream_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          isFull, isEmpty, doPush, doPop;

  assign isFull  = (level_q == (AW+1)'(DEPTH));
  assign isEmpty = (level_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign level_o = level_q;

  // Full/empty are judged on the start-of-cycle level, so a same-cycle pop never frees room for a push.
  always_comb begin
    doPush  = push_i && !isFull && !flush_i;
    doPop   = pop_i && !isEmpty && !flush_i;
    wptr_d  = wptr_q + AW'(doPush);
    rptr_d  = rptr_q + AW'(doPop);
    level_d = level_q + (AW+1)'(doPush) - (AW+1)'(doPop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wptr_q] <= data_i;
  end
endmodule

module add_one_stream_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic [63:0] add_one_in_data,
  output logic        add_one_call_valid,
  input  logic        add_one_call_stall,
  input  logic [63:0] add_one_out_data,
  input  logic        add_one_return_valid,
  output logic        add_one_return_stall
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic             wrLo, wrHi, wrCtrl, rdHi, flush, clrSticky, callFire, retFire;
  logic             inFull, inEmpty, outFull, outEmpty, shadowOk, chkSticky;
  logic [LW-1:0]    inLevel, outLevel;
  logic [63:0]      outHead;
  logic [31:0]      stage_q, stage_d, readdata_q, readdata_d, rdMux, chkCount;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [CNT_W-1:0] issued_q, issued_d, returned_q, returned_d;

  assign wrLo      = avs_write && (avs_address == 3'd0);
  assign wrHi      = avs_write && (avs_address == 3'd1);
  assign wrCtrl    = avs_write && (avs_address == 3'd4);
  assign rdHi      = avs_read  && (avs_address == 3'd3);
  assign flush     = wrCtrl && avs_writedata[1];
  assign clrSticky = wrCtrl && avs_writedata[0];

  assign inFull   = (inLevel == LW'(FIFO_DEPTH));
  assign inEmpty  = (inLevel == '0);
  assign outFull  = (outLevel == LW'(FIFO_DEPTH));
  assign outEmpty = (outLevel == '0);

  assign add_one_call_valid   = !inEmpty && shadowOk;
  assign add_one_return_stall = outFull;
  assign callFire             = add_one_call_valid && !add_one_call_stall;
  assign retFire              = add_one_return_valid && !add_one_return_stall;
  assign avs_readdata         = readdata_q;

  add_one_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) uInFifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (wrHi),
    .pop_i   (callFire),
    .flush_i (flush),
    .data_i  ({avs_writedata, stage_q}),
    .head_o  (add_one_in_data),
    .level_o (inLevel)
  );

  add_one_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) uOutFifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (retFire),
    .pop_i   (rdHi),
    .flush_i (flush),
    .data_i  (add_one_out_data),
    .head_o  (outHead),
    .level_o (outLevel)
  );

`ifdef ADD_ONE_BRIDGE_CHECK_EN
  logic [63:0]   shadowHead;
  logic [LW-1:0] shadowLevel;
  logic          shadowEmpty, chkEvent, misSticky_q, misSticky_d;
  logic [31:0]   mis_q, mis_d;

  add_one_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) uShadowFifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (callFire),
    .pop_i   (retFire),
    .flush_i (flush),
    .data_i  (add_one_in_data),
    .head_o  (shadowHead),
    .level_o (shadowLevel)
  );

  assign shadowOk    = (shadowLevel != LW'(FIFO_DEPTH));
  assign shadowEmpty = (shadowLevel == '0);
  assign chkEvent    = retFire && !shadowEmpty && (add_one_out_data != shadowHead + 64'd1);
  assign chkCount    = mis_q;
  assign chkSticky   = misSticky_q;

  // A new mismatch in the same cycle as a clear still counts, so the clear is applied first.
  always_comb begin
    mis_d       = clrSticky ? 32'd0 : mis_q;
    misSticky_d = (misSticky_q && !clrSticky) || chkEvent;
    if (chkEvent && (mis_d != 32'hFFFF_FFFF)) mis_d = mis_d + 32'd1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mis_q       <= '0;
      misSticky_q <= 1'b0;
    end else begin
      mis_q       <= mis_d;
      misSticky_q <= misSticky_d;
    end
  end
`else
  assign shadowOk  = 1'b1;
  assign chkCount  = '0;
  assign chkSticky = 1'b0;
`endif

  always_comb begin
    rdMux = '0;
    case (avs_address)
      3'd2:    rdMux = outEmpty ? 32'd0 : outHead[31:0];
      3'd3:    rdMux = outEmpty ? 32'd0 : outHead[63:32];
      3'd4:    rdMux = {8'(outLevel), 8'(inLevel), 8'd0, chkSticky, (issued_q != returned_q),
                        unf_q, ovf_q, outEmpty, outFull, inEmpty, inFull};
      3'd5:    rdMux = {16'(returned_q), 16'(issued_q)};
      3'd6:    rdMux = chkCount;
      default: rdMux = '0;
    endcase
  end

  // Sticky sets win over a same-cycle clear; a flush zeroes the counters after any transfer counts.
  always_comb begin
    stage_d    = wrLo ? avs_writedata : stage_q;
    ovf_d      = (ovf_q && !clrSticky) || (wrHi && inFull);
    unf_d      = (unf_q && !clrSticky) || (rdHi && outEmpty);
    issued_d   = issued_q + CNT_W'(callFire);
    returned_d = returned_q + CNT_W'(retFire);
    if (flush) begin
      issued_d   = '0;
      returned_d = '0;
    end
    readdata_d = avs_read ? rdMux : readdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stage_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      issued_q   <= '0;
      returned_q <= '0;
      readdata_q <= '0;
    end else begin
      stage_q    <= stage_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      readdata_q <= readdata_d;
    end
  end
endmodule
